ibuff_align: RTL and testbench

Instruction buffer and aligner sitting between the fetch stage and `predecode`. It accepts 32-bit fetch words into a halfword-granular ring buffer and re-aligns the mixed 16/32-bit RISC-V instruction stream, including 32-bit instructions that straddle fetch words. Each cycle it presents one instruction-aligned window on `IBuff_out`, which drives `predecode.IBuff_in`. It also tracks the PC of the presented instruction and supports flush/redirect.

---
 rtl/ibuff_align_pkg.sv | 13 +
 rtl/ibuff_align_hw_ring.sv | 60 ++++++
 rtl/ibuff_align.sv | 106 ++++++++++
 tb/tb_ibuff_align.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuff_align_pkg.sv
// Shared frontend definitions: halfword type and RVC opcode encoding used by the aligner.
package ibuff_align_pkg;

    localparam int         HW_W         = 16;
    localparam logic [1:0] RVC_OPC_FULL = 2'b11;

    typedef logic [HW_W-1:0] halfword_t;

    function automatic logic is_full_insn(input halfword_t hw);
        return hw[1:0] == RVC_OPC_FULL;
    endfunction

endpackage

// File: rtl/ibuff_align_hw_ring.sv
// Halfword ring buffer with up to two writes and two reads per cycle.
// Pointers wrap naturally at DEPTH because DEPTH is a power of two.
module ibuff_align_hw_ring
    import ibuff_align_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic [1:0]    i_wr_num,
    input  halfword_t     i_wr_hw0,
    input  halfword_t     i_wr_hw1,
    input  logic [1:0]    i_rd_num,
    output halfword_t     o_rd_hw0,
    output halfword_t     o_rd_hw1,
    output logic [CW-1:0] o_count
);

    halfword_t       r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   w_wr_ptr1;
    logic [AW-1:0]   w_rd_ptr1;

    assign w_wr_ptr1 = r_wr_ptr + AW'(1);
    assign w_rd_ptr1 = r_rd_ptr + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(i_rd_num);
            r_wr_ptr <= r_wr_ptr + AW'(i_wr_num);
            r_count  <= r_count + CW'(i_wr_num) - CW'(i_rd_num);
        end
    end

    // Storage needs no reset: reads are qualified by count in the aligner.
    always_ff @(posedge clk) begin
        if (!i_clear) begin
            if (i_wr_num != 2'd0) r_mem[r_wr_ptr]  <= i_wr_hw0;
            if (i_wr_num == 2'd2) r_mem[w_wr_ptr1] <= i_wr_hw1;
        end
    end

    assign o_rd_hw0 = r_mem[r_rd_ptr];
    assign o_rd_hw1 = r_mem[w_rd_ptr1];
    assign o_count  = r_count;

endmodule

// File: rtl/ibuff_align.sv
// Instruction buffer/aligner: re-aligns the 16/32-bit RISC-V stream from 32-bit fetch words
// into one instruction window per cycle for predecode, tracking PC and handling redirects.
module ibuff_align
    import ibuff_align_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 8,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [XLEN-1:0]          fetch_data,
    input  logic                     flush,
    input  logic [XLEN-1:0]          flush_pc,
    output logic [XLEN-1:0]          IBuff_out,
    output logic [XLEN-1:0]          ibuff_pc,
    output logic                     ibuff_valid,
    input  logic                     ibuff_ready,
    output logic [$clog2(DEPTH):0]   ibuff_count
);

    localparam int            CW           = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LP_FETCH_MAX = CW'(DEPTH - 2);

    logic [XLEN-1:0] r_head_pc;
    logic            r_skip_hw;

    halfword_t       w_h0;
    halfword_t       w_h1;
    halfword_t       w_wr_hw0;
    halfword_t       w_wr_hw1;
    logic [CW-1:0]   w_count;
    logic [1:0]      w_wr_num;
    logic [1:0]      w_rd_num;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    ibuff_align_hw_ring #(.DEPTH(DEPTH)) u_hw_ring (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (flush),
        .i_wr_num (w_wr_num),
        .i_wr_hw0 (w_wr_hw0),
        .i_wr_hw1 (w_wr_hw1),
        .i_rd_num (w_rd_num),
        .o_rd_hw0 (w_h0),
        .o_rd_hw1 (w_h1),
        .o_count  (w_count)
    );

    // Ready never looks at fetch_valid so fetch can't form a combinational loop through it.
    assign fetch_ready = (w_count <= LP_FETCH_MAX) && !flush;
    assign w_push      = fetch_valid && fetch_ready;

    assign w_full      = is_full_insn(w_h0);
    assign ibuff_valid = (w_count >= CW'(2)) || ((w_count == CW'(1)) && !w_full);
    assign w_pop       = ibuff_valid && ibuff_ready && !flush;

    always_comb begin
        w_wr_num = 2'd0;
        w_wr_hw0 = fetch_data[15:0];
        w_wr_hw1 = fetch_data[31:16];
        if (w_push) begin
            if (r_skip_hw) begin
                // Redirect landed mid-word: only the upper halfword is program-order valid.
                w_wr_num = 2'd1;
                w_wr_hw0 = fetch_data[31:16];
            end else begin
                w_wr_num = 2'd2;
            end
        end
    end

    always_comb begin
        w_rd_num = 2'd0;
        if (w_pop) w_rd_num = w_full ? 2'd2 : 2'd1;
    end

    always_comb begin
        IBuff_out = '0;
        if (ibuff_valid) begin
            if (w_full) IBuff_out = XLEN'({w_h1, w_h0});
            else        IBuff_out = XLEN'(w_h0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_pc <= RESET_PC;
            r_skip_hw <= RESET_PC[1];
        end else if (flush) begin
            r_head_pc <= flush_pc & ~XLEN'(1);
            r_skip_hw <= flush_pc[1];
        end else begin
            if (w_pop) r_head_pc <= r_head_pc + (w_full ? XLEN'(4) : XLEN'(2));
            if (w_push && r_skip_hw) r_skip_hw <= 1'b0;
        end
    end

    assign ibuff_pc    = r_head_pc;
    assign ibuff_count = w_count;

endmodule

// File: tb/tb_ibuff_align.sv
// Scoreboard bench for ibuff_align: expected windows are queued as fetch words are pushed
// and retired as the aligner presents them.
module tb_ibuff_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] IBuff_out;
    logic [31:0] ibuff_pc;
    logic        ibuff_valid;
    logic        ibuff_ready;
    logic [3:0]  ibuff_count;

    typedef struct {
        logic [31:0] win;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    ibuff_align #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .IBuff_out   (IBuff_out),
        .ibuff_pc    (ibuff_pc),
        .ibuff_valid (ibuff_valid),
        .ibuff_ready (ibuff_ready),
        .ibuff_count (ibuff_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [31:0] win, input logic [31:0] pc);
        exp_t e;
        e.win = win;
        e.pc  = pc;
        return e;
    endfunction

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        fetch_valid = 1'b1;
        fetch_data  = w;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({fetch_ready, ibuff_valid, IBuff_out, ibuff_pc, ibuff_count} !== {1'b1, 1'b0, 32'h0, 32'h0, 4'd0}) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%0b v=%0b out=%h pc=%h cnt=%0d want rdy=1 v=0 out=0 pc=0 cnt=0",
                     fetch_ready, ibuff_valid, IBuff_out, ibuff_pc, ibuff_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        exp_t e;
        do_flush(32'h0);
        exp_q.push_back(mk(32'h00A00093, 32'h0));
        push_word(32'h00A00093);
        e = exp_q.pop_front();
        total++;
        if ({ibuff_valid, IBuff_out, ibuff_pc} !== {1'b1, e.win, e.pc}) begin
            bad++;
            $display("FAIL basic_window: got v=%0b out=%h pc=%h want v=1 out=%h pc=%h",
                     ibuff_valid, IBuff_out, ibuff_pc, e.win, e.pc);
        end
        ibuff_ready = 1'b1;
        @(posedge clk); #1;
        ibuff_ready = 1'b0;
        total++;
        if ({ibuff_pc, ibuff_count, ibuff_valid} !== {32'h4, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL basic_pop: got pc=%h cnt=%0d v=%0b want pc=4 cnt=0 v=0", ibuff_pc, ibuff_count, ibuff_valid);
        end
    endtask

    task automatic test_compressed();
        exp_t e;
        do_flush(32'h0);
        exp_q.push_back(mk(32'h00000505, 32'h0));
        exp_q.push_back(mk(32'h00000051, 32'h2));
        push_word(32'h00510505);
        ibuff_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (ibuff_valid) begin
                e = exp_q.pop_front();
                total++;
                if ({IBuff_out, ibuff_pc} !== {e.win, e.pc}) begin
                    bad++;
                    $display("FAIL compressed_window: got out=%h pc=%h want out=%h pc=%h", IBuff_out, ibuff_pc, e.win, e.pc);
                end
            end
            @(posedge clk); #1;
        end
        ibuff_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || ibuff_pc !== 32'h4 || ibuff_count !== 4'd0) begin
            bad++;
            $display("FAIL compressed_end: got left=%0d pc=%h cnt=%0d want left=0 pc=4 cnt=0", exp_q.size(), ibuff_pc, ibuff_count);
        end
    endtask

    task automatic test_straddle();
        exp_t e;
        do_flush(32'h0);
        exp_q.push_back(mk(32'h00000001, 32'h0));
        push_word(32'h00930001);
        e = exp_q.pop_front();
        total++;
        if ({ibuff_valid, IBuff_out, ibuff_pc} !== {1'b1, e.win, e.pc}) begin
            bad++;
            $display("FAIL straddle_first: got v=%0b out=%h pc=%h want v=1 out=%h pc=%h", ibuff_valid, IBuff_out, ibuff_pc, e.win, e.pc);
        end
        ibuff_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ibuff_valid, IBuff_out, ibuff_count, ibuff_pc} !== {1'b0, 32'h0, 4'd1, 32'h2}) begin
            bad++;
            $display("FAIL straddle_hold: got v=%0b out=%h cnt=%0d pc=%h want v=0 out=0 cnt=1 pc=2", ibuff_valid, IBuff_out, ibuff_count, ibuff_pc);
        end
        ibuff_ready = 1'b0;
        exp_q.push_back(mk(32'h00A00093, 32'h2));
        exp_q.push_back(mk(32'h00000000, 32'h6));
        push_word(32'h000000A0);
        ibuff_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (ibuff_valid) begin
                e = exp_q.pop_front();
                total++;
                if ({IBuff_out, ibuff_pc} !== {e.win, e.pc}) begin
                    bad++;
                    $display("FAIL straddle_window: got out=%h pc=%h want out=%h pc=%h", IBuff_out, ibuff_pc, e.win, e.pc);
                end
            end
            @(posedge clk); #1;
        end
        ibuff_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || ibuff_pc !== 32'h8) begin
            bad++;
            $display("FAIL straddle_end: got left=%0d pc=%h want left=0 pc=8", exp_q.size(), ibuff_pc);
        end
    endtask

    task automatic test_full_boundary();
        exp_t        e;
        logic [31:0] w;
        do_flush(32'h0);
        ibuff_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = 32'h00100013 + (32'(k) << 20);
            exp_q.push_back(mk(w, 32'(4 * k)));
            fetch_valid = 1'b1;
            fetch_data  = w;
            @(posedge clk); #1;
            total++;
            if ({ibuff_count, fetch_ready} !== {4'(2 * (k + 1)), (k < 3) ? 1'b1 : 1'b0}) begin
                bad++;
                $display("FAIL fill_step%0d: got cnt=%0d rdy=%0b want cnt=%0d rdy=%0b",
                         k, ibuff_count, fetch_ready, 2 * (k + 1), (k < 3));
            end
        end
        fetch_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        total++;
        if (ibuff_count !== 4'd8) begin
            bad++;
            $display("FAIL fill_blocked: got cnt=%0d want cnt=8", ibuff_count);
        end
        ibuff_ready = 1'b1;
        #1;
        e = exp_q.pop_front();
        total++;
        if ({fetch_ready, IBuff_out, ibuff_pc} !== {1'b0, e.win, e.pc}) begin
            bad++;
            $display("FAIL full_pop_cycle: got rdy=%0b out=%h pc=%h want rdy=0 out=%h pc=%h", fetch_ready, IBuff_out, ibuff_pc, e.win, e.pc);
        end
        @(posedge clk); #1;
        ibuff_ready = 1'b0;
        fetch_valid = 1'b0;
        total++;
        if ({ibuff_count, fetch_ready} !== {4'd6, 1'b1}) begin
            bad++;
            $display("FAIL after_full_pop: got cnt=%0d rdy=%0b want cnt=6 rdy=1", ibuff_count, fetch_ready);
        end
        ibuff_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (ibuff_valid) begin
                e = exp_q.pop_front();
                total++;
                if ({IBuff_out, ibuff_pc} !== {e.win, e.pc}) begin
                    bad++;
                    $display("FAIL full_drain: got out=%h pc=%h want out=%h pc=%h", IBuff_out, ibuff_pc, e.win, e.pc);
                end
            end
            @(posedge clk); #1;
        end
        ibuff_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || ibuff_count !== 4'd0) begin
            bad++;
            $display("FAIL full_drain_end: got left=%0d cnt=%0d want left=0 cnt=0", exp_q.size(), ibuff_count);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] w;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] exp_pc;
        logic        kind_full;
        do_flush(32'h0);
        exp_pc = 32'h0;
        for (int c = 0; c < 120; c++) begin
            fetch_valid = ($urandom_range(0, 3) != 0);
            ibuff_ready = ($urandom_range(0, 2) != 0);
            kind_full   = $urandom_range(0, 1) == 1;
            w           = $urandom();
            if (kind_full) begin
                w[1:0] = 2'b11;
            end else begin
                lo = w[15:0];
                hi = w[31:16];
                if (lo[1:0] == 2'b11) lo[1:0] = 2'b01;
                if (hi[1:0] == 2'b11) hi[1:0] = 2'b10;
                w = {hi, lo};
            end
            fetch_data = w;
            #1;
            if (ibuff_valid && ibuff_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected: got out=%h pc=%h want no valid window", IBuff_out, ibuff_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({IBuff_out, ibuff_pc} !== {e.win, e.pc}) begin
                        bad++;
                        $display("FAIL b2b_window: got out=%h pc=%h want out=%h pc=%h", IBuff_out, ibuff_pc, e.win, e.pc);
                    end
                end
            end
            if (fetch_valid && fetch_ready) begin
                if (kind_full) begin
                    exp_q.push_back(mk(w, exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end else begin
                    exp_q.push_back(mk({16'h0, w[15:0]}, exp_pc));
                    exp_q.push_back(mk({16'h0, w[31:16]}, exp_pc + 32'd2));
                    exp_pc = exp_pc + 32'd4;
                end
            end
            @(posedge clk); #1;
        end
        fetch_valid = 1'b0;
        ibuff_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (ibuff_valid) begin
                e = exp_q.pop_front();
                total++;
                if ({IBuff_out, ibuff_pc} !== {e.win, e.pc}) begin
                    bad++;
                    $display("FAIL b2b_drain: got out=%h pc=%h want out=%h pc=%h", IBuff_out, ibuff_pc, e.win, e.pc);
                end
            end
            @(posedge clk); #1;
        end
        ibuff_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || ibuff_count !== 4'd0 || ibuff_pc !== exp_pc) begin
            bad++;
            $display("FAIL b2b_end: got left=%0d cnt=%0d pc=%h want left=0 cnt=0 pc=%h", exp_q.size(), ibuff_count, ibuff_pc, exp_pc);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        do_flush(32'h0);
        push_word(32'h00A00093);
        flush       = 1'b1;
        flush_pc    = 32'h102;
        fetch_valid = 1'b1;
        fetch_data  = 32'hDEADBEEF;
        #1;
        total++;
        if (fetch_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready: got rdy=%0b want rdy=0", fetch_ready);
        end
        @(posedge clk); #1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        exp_q.delete();
        total++;
        if ({ibuff_count, ibuff_valid, IBuff_out, ibuff_pc} !== {4'd0, 1'b0, 32'h0, 32'h102}) begin
            bad++;
            $display("FAIL flush_state: got cnt=%0d v=%0b out=%h pc=%h want cnt=0 v=0 out=0 pc=102",
                     ibuff_count, ibuff_valid, IBuff_out, ibuff_pc);
        end
        exp_q.push_back(mk(32'h00001111, 32'h102));
        push_word(32'h11112222);
        e = exp_q.pop_front();
        total++;
        if ({ibuff_count, ibuff_valid, IBuff_out, ibuff_pc} !== {4'd1, 1'b1, e.win, e.pc}) begin
            bad++;
            $display("FAIL flush_skip_hw: got cnt=%0d v=%0b out=%h pc=%h want cnt=1 v=1 out=%h pc=%h",
                     ibuff_count, ibuff_valid, IBuff_out, ibuff_pc, e.win, e.pc);
        end
        ibuff_ready = 1'b1;
        @(posedge clk); #1;
        ibuff_ready = 1'b0;
        total++;
        if ({ibuff_count, ibuff_pc} !== {4'd0, 32'h104}) begin
            bad++;
            $display("FAIL flush_pop: got cnt=%0d pc=%h want cnt=0 pc=104", ibuff_count, ibuff_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_flush(32'h102);
        ibuff_ready = 1'b0;
        push_word(32'h00050001);
        push_word(32'h00090005);
        push_word(32'h000D0009);
        total++;
        if (ibuff_count !== 4'd5) begin
            bad++;
            $display("FAIL pre_reset_count: got cnt=%0d want cnt=5", ibuff_count);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({fetch_ready, ibuff_valid, IBuff_out, ibuff_pc, ibuff_count} !== {1'b1, 1'b0, 32'h0, 32'h0, 4'd0}) begin
            bad++;
            $display("FAIL async_reset: got rdy=%0b v=%0b out=%h pc=%h cnt=%0d want rdy=1 v=0 out=0 pc=0 cnt=0",
                     fetch_ready, ibuff_valid, IBuff_out, ibuff_pc, ibuff_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        ibuff_ready = 1'b0;
        test_reset();
        test_basic();
        test_compressed();
        test_straddle();
        test_full_boundary();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
